// File: rtl/loran_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loran_pkg
// Description : Shared types and constants for the LORAN pulse generator.
// Revision    : 1.0  initial release
// ============================================================================
package loran_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] GRI_A = 2'b00;
  localparam logic [1:0] GRI_B = 2'b11;

  // Phase codes, bit k = pulse k, 1 = '-'. Slave codes leave bit 8 at 0.
  localparam logic [8:0] PHASE_MASTER_A = 9'b010101100;
  localparam logic [8:0] PHASE_MASTER_B = 9'b100000110;
  localparam logic [8:0] PHASE_SLAVE_A  = 9'b001100000;
  localparam logic [8:0] PHASE_SLAVE_B  = 9'b011001010;

  localparam logic [3:0] MASTER_PULSES = 4'd9;
  localparam logic [3:0] SLAVE_PULSES  = 4'd8;

endpackage
`default_nettype wire

// File: rtl/loran_phase_code.sv
`default_nettype none
// ============================================================================
// Module      : loran_phase_code
// Description : Combinational lookup of the phase bit for one pulse.
// Revision    : 1.0  initial release
// ============================================================================
module loran_phase_code
  import loran_pkg::*;
(
  input  logic       i_mxy,
  input  logic [1:0] i_gri_cycle,
  input  logic [3:0] i_pulse_index,
  output logic       o_phase
);

  logic [8:0] w_code;

  always_comb begin
    w_code  = PHASE_SLAVE_A;
    o_phase = 1'b0;
    if (i_mxy) begin
      w_code = (i_gri_cycle == GRI_B) ? PHASE_MASTER_B : PHASE_MASTER_A;
    end else begin
      w_code = (i_gri_cycle == GRI_B) ? PHASE_SLAVE_B : PHASE_SLAVE_A;
    end
    if (i_pulse_index <= 4'd8) begin
      o_phase = w_code[i_pulse_index];
    end
  end

endmodule
`default_nettype wire

// File: rtl/loran_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : loran_pulse_gen
// Description : LORAN GRI sequencer emitting phase-coded pulse strobes.
// Revision    : 1.0  initial release
// ============================================================================
module loran_pulse_gen
  import loran_pkg::*;
#(
  parameter int GRI_LEN       = 60000,
  parameter int PULSE_SPACING = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       enable,
  input  logic       gri_mxy,
  output logic       gri_data_valid,
  output logic       pulse_valid,
  output logic [3:0] pulse_index,
  output logic       pulse_phase,
  output logic [1:0] gri_cycle,
  output logic       gri_done
);

  localparam logic [15:0] c_cyc_last  = 16'(GRI_LEN - 1);
  localparam logic [15:0] c_slot_last = 16'(PULSE_SPACING - 1);
  localparam logic [3:0]  c_slot_stop = MASTER_PULSES + 4'd1;

  state_t      r_state, w_nxt_state;
  logic [15:0] r_cyc_cnt, w_nxt_cyc;
  logic [15:0] r_slot_cnt, w_nxt_slot_cnt;
  logic [3:0]  r_slot_num, w_nxt_slot_num;
  logic        r_mxy, w_nxt_mxy;
  logic [1:0]  r_gri_cycle, w_nxt_cycle;
  logic        w_nxt_active, w_nxt_hit, w_nxt_phase;
  logic [3:0]  w_nxt_index;

  logic        r_gri_data_valid, r_pulse_valid, r_pulse_phase, r_gri_done;
  logic [3:0]  r_pulse_index;

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cyc      = r_cyc_cnt;
    w_nxt_slot_cnt = r_slot_cnt;
    w_nxt_slot_num = r_slot_num;
    w_nxt_mxy      = r_mxy;
    w_nxt_cycle    = r_gri_cycle;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_nxt_state    = ST_RUN;
          w_nxt_cyc      = 16'd0;
          w_nxt_slot_cnt = 16'd0;
          w_nxt_slot_num = 4'd0;
          w_nxt_cycle    = GRI_A;
          w_nxt_mxy      = gri_mxy;
        end
      end
      default: begin
        if (r_cyc_cnt == c_cyc_last) begin
          w_nxt_cyc      = 16'd0;
          w_nxt_slot_cnt = 16'd0;
          w_nxt_slot_num = 4'd0;
          if (enable) begin
            w_nxt_state = ST_RUN;
            w_nxt_cycle = (r_gri_cycle == GRI_A) ? GRI_B : GRI_A;
            w_nxt_mxy   = gri_mxy;
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else begin
          // Mid-GRI the FSM only tracks whether enable is still held.
          w_nxt_state = enable ? ST_RUN : ST_DRAIN;
          w_nxt_cyc   = r_cyc_cnt + 16'd1;
          if (r_slot_cnt == c_slot_last) begin
            w_nxt_slot_cnt = 16'd0;
            if (r_slot_num != c_slot_stop) begin
              w_nxt_slot_num = r_slot_num + 4'd1;
            end
          end else begin
            w_nxt_slot_cnt = r_slot_cnt + 16'd1;
          end
        end
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with cyc_cnt.
  assign w_nxt_active = (w_nxt_state != ST_IDLE);
  assign w_nxt_hit    = w_nxt_active && (w_nxt_slot_cnt == 16'd0) &&
                        ((w_nxt_slot_num < SLAVE_PULSES) ||
                         (w_nxt_mxy && (w_nxt_slot_num == MASTER_PULSES)));
  assign w_nxt_index  = (w_nxt_slot_num < SLAVE_PULSES) ? w_nxt_slot_num : SLAVE_PULSES;

  loran_phase_code u_phase_code (
    .i_mxy         (w_nxt_mxy),
    .i_gri_cycle   (w_nxt_cycle),
    .i_pulse_index (w_nxt_index),
    .o_phase       (w_nxt_phase)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state          <= ST_IDLE;
      r_cyc_cnt        <= 16'd0;
      r_slot_cnt       <= 16'd0;
      r_slot_num       <= 4'd0;
      r_mxy            <= 1'b0;
      r_gri_cycle      <= GRI_A;
      r_gri_data_valid <= 1'b0;
      r_pulse_valid    <= 1'b0;
      r_pulse_index    <= 4'd0;
      r_pulse_phase    <= 1'b0;
      r_gri_done       <= 1'b0;
    end else begin
      r_state          <= w_nxt_state;
      r_cyc_cnt        <= w_nxt_cyc;
      r_slot_cnt       <= w_nxt_slot_cnt;
      r_slot_num       <= w_nxt_slot_num;
      r_mxy            <= w_nxt_mxy;
      r_gri_cycle      <= w_nxt_cycle;
      r_gri_data_valid <= w_nxt_active && (w_nxt_cyc != c_cyc_last);
      r_gri_done       <= w_nxt_active && (w_nxt_cyc == c_cyc_last);
      r_pulse_valid    <= w_nxt_hit;
      if (w_nxt_hit) begin
        r_pulse_index <= w_nxt_index;
        r_pulse_phase <= w_nxt_phase;
      end
    end
  end

  assign gri_data_valid = r_gri_data_valid;
  assign pulse_valid    = r_pulse_valid;
  assign pulse_index    = r_pulse_index;
  assign pulse_phase    = r_pulse_phase;
  assign gri_cycle      = r_gri_cycle;
  assign gri_done       = r_gri_done;

endmodule
`default_nettype wire
